// File: rtl/pong_pkg.sv
// Shared types, widths and BCD helpers for the Pong score keeper.
package pong_pkg;

  localparam int DIGIT_W = 4;

  // Match sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  // Default winning score and its BCD digits.
  localparam int WIN_SCORE_DEF = 11;

  // Tens digit of a decimal value in 0..99.
  function automatic logic [DIGIT_W-1:0] bcd_tens(input int v);
    return DIGIT_W'(v / 10);
  endfunction

  // Ones digit of a decimal value in 0..99.
  function automatic logic [DIGIT_W-1:0] bcd_ones(input int v);
    return DIGIT_W'(v % 10);
  endfunction

  localparam logic [DIGIT_W-1:0] WIN_TENS_DEF = bcd_tens(WIN_SCORE_DEF);
  localparam logic [DIGIT_W-1:0] WIN_ONES_DEF = bcd_ones(WIN_SCORE_DEF);

  // True when the BCD score tens:ones, once incremented, equals wt:wo.
  // Lets the FSM decide the win on the same edge the point is counted.
  function automatic logic bcd_next_equals(
    input logic [DIGIT_W-1:0] tens,
    input logic [DIGIT_W-1:0] ones,
    input logic [DIGIT_W-1:0] wt,
    input logic [DIGIT_W-1:0] wo
  );
    logic [DIGIT_W-1:0] nt;
    logic [DIGIT_W-1:0] no;
    if (ones == DIGIT_W'(9)) begin
      nt = tens + DIGIT_W'(1);
      no = '0;
    end else begin
      nt = tens;
      no = ones + DIGIT_W'(1);
    end
    return (nt == wt) && (no == wo);
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD up-counter for one player's score. Clear beats increment.
module bcd2_counter
  import pong_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] ones
);

  logic [DIGIT_W-1:0] tens_q, tens_d;
  logic [DIGIT_W-1:0] ones_q, ones_d;

  // Next digit values: clear, BCD increment with carry, or hold.
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (clr) begin
      tens_d = '0;
      ones_d = '0;
    end else if (inc) begin
      if (ones_q == DIGIT_W'(9)) begin
        ones_d = '0;
        tens_d = tens_q + DIGIT_W'(1);
      end else begin
        ones_d = ones_q + DIGIT_W'(1);
      end
    end
  end

  // Digit registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;

endmodule

// File: rtl/pong_score.sv
// Two-player score keeper and rally sequencer for Pong.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   ST_IDLE  | after reset, scores 00-00, waiting for start press
//   ST_SERVE | ball parked, serve delay counting down
//   ST_PLAY  | rally live, ball enabled, point pulses counted
//   ST_OVER  | match won, scores and winner frozen until start
module pong_score
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = WIN_SCORE_DEF,
  parameter int SERVE_DELAY = 50_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               point_l,
  input  logic               point_r,
  output logic [DIGIT_W-1:0] dig0,
  output logic [DIGIT_W-1:0] dig1,
  output logic [DIGIT_W-1:0] dig2,
  output logic [DIGIT_W-1:0] dig3,
  output logic               serve,
  output logic               ball_en,
  output logic               game_over,
  output logic               winner
);

  localparam int                 CNT_W    = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(SERVE_DELAY - 1);
  localparam logic [DIGIT_W-1:0] WIN_TENS = bcd_tens(WIN_SCORE);
  localparam logic [DIGIT_W-1:0] WIN_ONES = bcd_ones(WIN_SCORE);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               start_q;
  logic               start_rise;

  logic               serve_q, serve_d;
  logic               ball_en_q, ball_en_d;
  logic               game_over_q, game_over_d;
  logic               winner_q, winner_d;

  logic               clr_scores;
  logic               inc_l, inc_r;
  logic [DIGIT_W-1:0] l_tens, l_ones, r_tens, r_ones;
  logic               l_wins, r_wins;

  // Start edge detector. The copy tracks the button even while reset is
  // held, so a button still down when reset releases is not seen as a press.
  always_ff @(posedge clk) begin
    start_q <= start;
  end

  assign start_rise = start & ~start_q;

  assign l_wins = bcd_next_equals(l_tens, l_ones, WIN_TENS, WIN_ONES);
  assign r_wins = bcd_next_equals(r_tens, r_ones, WIN_TENS, WIN_ONES);

  // State and serve-delay counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter, score strobes and winner capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_scores = 1'b0;
    inc_l      = 1'b0;
    inc_r      = 1'b0;
    winner_d   = winner_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          clr_scores = 1'b1;
          cnt_d      = CNT_LOAD;
          state_d    = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (cnt_q == '0) begin
          state_d = ST_PLAY;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_PLAY: begin
        // Simultaneous points resolve to the left player only.
        if (point_l) begin
          inc_l = 1'b1;
          if (l_wins) begin
            winner_d = 1'b0;
            state_d  = ST_OVER;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = ST_SERVE;
          end
        end else if (point_r) begin
          inc_r = 1'b1;
          if (r_wins) begin
            winner_d = 1'b1;
            state_d  = ST_OVER;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = ST_SERVE;
          end
        end
      end
      ST_OVER: begin
        if (start_rise) begin
          clr_scores = 1'b1;
          cnt_d      = CNT_LOAD;
          state_d    = ST_SERVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line
  // up with the state they describe.
  always_comb begin
    serve_d     = (state_q == ST_SERVE) && (state_d == ST_PLAY);
    ball_en_d   = (state_d == ST_PLAY);
    game_over_d = (state_d == ST_OVER);
  end

  // Output registers; reset drops any serve pulse that was about to fire.
  always_ff @(posedge clk) begin
    if (reset) begin
      serve_q     <= 1'b0;
      ball_en_q   <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
    end else begin
      serve_q     <= serve_d;
      ball_en_q   <= ball_en_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  bcd2_counter u_score_l (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_scores),
    .inc   (inc_l),
    .tens  (l_tens),
    .ones  (l_ones)
  );

  bcd2_counter u_score_r (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_scores),
    .inc   (inc_r),
    .tens  (r_tens),
    .ones  (r_ones)
  );

  assign dig0      = l_tens;
  assign dig1      = l_ones;
  assign dig2      = r_tens;
  assign dig3      = r_ones;
  assign serve     = serve_q;
  assign ball_en   = ball_en_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule
